high_bit_search_pipe: RTL and testbench
=======================================

Name: high_bit_search_pipe

Overview:
Pipelined, parametrised leading-one / trailing-one detector. It is the next generation of high_bit_search. Width is generalised and split into segments. Each word carries a runtime MSB/LSB search mode and a sideband tag, and the block has a valid/ready handshake with full backpressure. It sits between a word source and any consumer that needs the bit index, such as a normaliser, arbiter or free-slot finder.

Parameters:
INPUT_WIDTH, 32, searched word width; >= 2; must be a multiple of SEG_WIDTH.
SEG_WIDTH, 8, stage-1 segment width; power of two; 2..INPUT_WIDTH.
TAG_WIDTH, 4, width of the opaque sideband tag carried alongside each word; >= 1.

Ports:
clk  input  1  single clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
input_data  input  INPUT_WIDTH  word to search.
in_lsb  input  1  0 = find highest set bit, 1 = find lowest set bit.
in_tag  input  TAG_WIDTH  sideband returned unchanged with the result.
in_valid  input  1  input word is present.
in_ready  output  1  block accepts the word this cycle.
out_valid  output  1  result is present.
out_ready  input  1  consumer accepts the result.
out_found  output  1  input word had at least one set bit.
out_index  output  IDX_W  bit index of the found bit; IDX_W = $clog2(INPUT_WIDTH).
out_tag  output  TAG_WIDTH  tag of the word that produced this result.

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- Two register stages.
  - S1: per-segment search. For each of NSEG = INPUT_WIDTH/SEG_WIDTH segments, register seg_hit (OR of the segment) and seg_idx (local index, honouring in_lsb). Also register the mode bit, the tag and a valid bit.
  - S2: choose the winning segment (highest-numbered hit for MSB, lowest-numbered hit for LSB). out_index = seg_number*SEG_WIDTH + seg_idx. out_found = OR of seg_hit.
- Latency: exactly 2 cycles from input transfer to out_valid when there is no stall. Throughput is 1 word/cycle.
- Stall:
  - adv = !out_valid || out_ready, and in_ready = adv.
  - When adv = 0, both stages hold their contents.
  - A bubble in S1 is not collapsed during a stall.
- Zero input: out_found = 0, out_index = 0. The tag is still returned.
- Mode is per word: back-to-back words with different in_lsb values must each use their own mode.
- Full-width edge cases:
  - bit 0 only: index 0 in both modes.
  - bit INPUT_WIDTH-1 only: index INPUT_WIDTH-1 in both modes.
  - all ones: MSB mode gives INPUT_WIDTH-1, LSB mode gives 0.
- SEG_WIDTH = INPUT_WIDTH degenerates to NSEG = 1. The S2 select becomes trivial but the latency stays 2.
- Reset:
  - Clears both stage valid bits, so out_valid = 0.
  - Sets out_found = 0, out_index = 0, out_tag = 0.
  - in_ready is 1 in the cycle after rst deasserts.
  - Asserting rst mid-stream discards all in-flight words. No result for them ever appears.
  - While rst = 1, in_ready = 0.
- Datapath registers other than the valid bits may be reset or left unreset, except that out_* must read 0 after reset.

Optional Feature:
HBS_ONEHOT_EN
- Defined: adds output port out_onehot [INPUT_WIDTH-1:0], registered in S2 with the same timing as out_index. Its value is 1 << out_index when out_found = 1, otherwise all zeros. It is reset to 0.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package high_bit_search_pkg:
  - function clog2-style IDX width helper;
  - localparam defaults (INPUT_WIDTH, SEG_WIDTH, TAG_WIDTH);
  - mode encoding constants SEARCH_MSB = 1'b0, SEARCH_LSB = 1'b1.
- One sub-module hbs_seg_search (parameter SEG_WIDTH), instantiated NSEG times in S1. It is purely combinational: data plus lsb in, hit plus local index out. Both stage registers live in the top module.

Test Plan:
- INPUT_WIDTH=8, SEG_WIDTH=4, stream 0xDE,0xAD,0xBE,0xEF,0xCA,0xFE,0xBA,0xBA,0xDE,0xDA in MSB mode with out_ready=1 -> index 7 for every word, found=1, first out_valid exactly 2 cycles after the first transfer, results back-to-back.
- Same stream in LSB mode -> 1,0,1,0,1,1,1,1,1,1.
- INPUT_WIDTH=32, SEG_WIDTH=8 -> 0x00010000 gives index 16 in both modes; 0x80000001 gives MSB 31 and LSB 0; 0x00000000 gives found=0, index=0, tag echoed.
- Alternate in_lsb each cycle on 0x0000F0F0 with tags 1..4 -> 15,4,15,4 with tags 1,2,3,4 in order.
- Hold out_ready=0 for 5 cycles with a full pipe -> in_ready=0, out_* stable, no word lost or duplicated after release; compare against a scoreboard for 100 random words with random out_ready.
- Assert rst for 1 cycle with 2 words in flight -> out_valid=0 next cycle, neither word emerges. With HBS_ONEHOT_EN, 0x00000040 -> out_onehot=0x00000040.

Source files
------------

// File: rtl/high_bit_search_pkg.sv
// Shared defaults, search-mode encoding and index-width helper for the high-bit search pipeline.
package high_bit_search_pkg;

  localparam int DEF_INPUT_WIDTH = 32;
  localparam int DEF_SEG_WIDTH   = 8;
  localparam int DEF_TAG_WIDTH   = 4;

  localparam logic SEARCH_MSB = 1'b0;
  localparam logic SEARCH_LSB = 1'b1;

  // Bits needed to index n positions; never less than one so ports stay legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hbs_seg_search.sv
// Combinational leading/trailing-one search over one segment; no state, no handshake.
// lsb selects the lowest set bit, otherwise the highest; idx is 0 when the segment is empty.
module hbs_seg_search
  import high_bit_search_pkg::*;
#(
  parameter int  SEG_WIDTH = DEF_SEG_WIDTH,
  localparam int SIDX_W    = idx_width(SEG_WIDTH)
) (
  input  logic [SEG_WIDTH-1:0] data,
  input  logic                 lsb,
  output logic                 hit,
  output logic [SIDX_W-1:0]    idx
);

  always_comb begin
    hit = |data;
    idx = '0;
    if (lsb == SEARCH_LSB) begin
      for (int i = SEG_WIDTH - 1; i >= 0; i--) begin
        if (data[i]) idx = SIDX_W'(i);
      end
    end else begin
      for (int i = 0; i < SEG_WIDTH; i++) begin
        if (data[i]) idx = SIDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/high_bit_search_pipe.sv
// Pipelined leading/trailing-one detector with per-word mode and tag; 2-cycle latency, 1 word/cycle.
// Both stages stall together when the output is held (in_ready = !out_valid || out_ready); HBS_ONEHOT_EN adds out_onehot.
module high_bit_search_pipe
  import high_bit_search_pkg::*;
#(
  parameter int  INPUT_WIDTH = DEF_INPUT_WIDTH,
  parameter int  SEG_WIDTH   = DEF_SEG_WIDTH,
  parameter int  TAG_WIDTH   = DEF_TAG_WIDTH,
  localparam int IDX_W       = idx_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INPUT_WIDTH-1:0] input_data,
  input  logic                   in_lsb,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_found,
  output logic [IDX_W-1:0]       out_index,
`ifdef HBS_ONEHOT_EN
  output logic [INPUT_WIDTH-1:0] out_onehot,
`endif
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int NSEG   = INPUT_WIDTH / SEG_WIDTH;
  localparam int SIDX_W = idx_width(SEG_WIDTH);

  logic                         adv;
  logic                         in_xfer;
  logic [NSEG-1:0]              seg_hit;
  logic [NSEG-1:0][SIDX_W-1:0]  seg_idx;

  logic                         s1_vld;
  logic                         s1_lsb;
  logic [TAG_WIDTH-1:0]         s1_tag;
  logic [NSEG-1:0]              s1_hit;
  logic [NSEG-1:0][SIDX_W-1:0]  s1_idx;

  logic                         win_found;
  logic [IDX_W-1:0]             win_idx;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !rst;
  assign in_xfer  = in_valid && in_ready;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    hbs_seg_search #(
      .SEG_WIDTH (SEG_WIDTH)
    ) u_seg (
      .data (input_data[g*SEG_WIDTH +: SEG_WIDTH]),
      .lsb  (in_lsb),
      .hit  (seg_hit[g]),
      .idx  (seg_idx[g])
    );
  end

  // Stage 1: per-segment results; a bubble is loaded as-is so it is never collapsed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_lsb <= SEARCH_MSB;
      s1_tag <= '0;
      s1_hit <= '0;
      s1_idx <= '0;
    end else if (adv) begin
      s1_vld <= in_xfer;
      if (in_xfer) begin
        s1_lsb <= in_lsb;
        s1_tag <= in_tag;
        s1_hit <= seg_hit;
        s1_idx <= seg_idx;
      end
    end
  end

  // Winning segment: last hit in scan order, scanning upward for MSB and downward for LSB.
  always_comb begin
    win_found = |s1_hit;
    win_idx   = '0;
    if (s1_lsb == SEARCH_LSB) begin
      for (int s = NSEG - 1; s >= 0; s--) begin
        if (s1_hit[s]) win_idx = IDX_W'(s * SEG_WIDTH) + IDX_W'(s1_idx[s]);
      end
    end else begin
      for (int s = 0; s < NSEG; s++) begin
        if (s1_hit[s]) win_idx = IDX_W'(s * SEG_WIDTH) + IDX_W'(s1_idx[s]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_found  <= 1'b0;
      out_index  <= '0;
      out_tag    <= '0;
`ifdef HBS_ONEHOT_EN
      out_onehot <= '0;
`endif
    end else if (adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_found  <= win_found;
        out_index  <= win_idx;
        out_tag    <= s1_tag;
`ifdef HBS_ONEHOT_EN
        out_onehot <= win_found ? (INPUT_WIDTH'(1) << win_idx) : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_high_bit_search_pipe.sv
// Directed and scoreboarded random bench for high_bit_search_pipe at INPUT_WIDTH=32, SEG_WIDTH=8.
module tb_high_bit_search_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_data;
  logic        in_lsb;
  logic [3:0]  in_tag;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic        out_found;
  logic [4:0]  out_index;
  logic [3:0]  out_tag;
`ifdef HBS_ONEHOT_EN
  logic [31:0] out_onehot;
`endif

  high_bit_search_pipe #(
    .INPUT_WIDTH (32),
    .SEG_WIDTH   (8),
    .TAG_WIDTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .input_data (input_data),
    .in_lsb     (in_lsb),
    .in_tag     (in_tag),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_found  (out_found),
    .out_index  (out_index),
`ifdef HBS_ONEHOT_EN
    .out_onehot (out_onehot),
`endif
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        found;
    logic [4:0]  idx;
    logic [3:0]  tag;
    logic [31:0] oh;
  } exp_t;

  typedef struct packed {
    logic [31:0] d;
    logic        lsb;
    logic [3:0]  tag;
    logic        f;
    logic [4:0]  idx;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rx_cnt = 0;
  int   t_in = 0;
  bit   lat_arm = 0;
  bit   lat_wait = 0;
  bit   hold_pend = 0;
  bit   rnd_done = 0;
  logic [9:0] held;

  logic [7:0] stream_b [10] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA, 8'hFE, 8'hBA, 8'hBA, 8'hDE, 8'hDA};
  int         lsb_exp  [10] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1};

  vec_t vecs [21] = '{
    '{32'h0001_0000, 1'b0, 4'd1,  1'b1, 5'd16},
    '{32'h0001_0000, 1'b1, 4'd2,  1'b1, 5'd16},
    '{32'h8000_0001, 1'b0, 4'd3,  1'b1, 5'd31},
    '{32'h8000_0001, 1'b1, 4'd4,  1'b1, 5'd0},
    '{32'h0000_0000, 1'b0, 4'd5,  1'b0, 5'd0},
    '{32'h0000_0000, 1'b1, 4'd6,  1'b0, 5'd0},
    '{32'h0000_0001, 1'b0, 4'd7,  1'b1, 5'd0},
    '{32'h0000_0001, 1'b1, 4'd8,  1'b1, 5'd0},
    '{32'h8000_0000, 1'b0, 4'd9,  1'b1, 5'd31},
    '{32'h8000_0000, 1'b1, 4'd10, 1'b1, 5'd31},
    '{32'hFFFF_FFFF, 1'b0, 4'd11, 1'b1, 5'd31},
    '{32'hFFFF_FFFF, 1'b1, 4'd12, 1'b1, 5'd0},
    '{32'h0000_0040, 1'b0, 4'd13, 1'b1, 5'd6},
    '{32'h0080_0100, 1'b0, 4'd14, 1'b1, 5'd23},
    '{32'h0080_0100, 1'b1, 4'd15, 1'b1, 5'd8},
    '{32'h00FF_0000, 1'b0, 4'd0,  1'b1, 5'd23},
    '{32'h00FF_0000, 1'b1, 4'd0,  1'b1, 5'd16},
    '{32'h0000_F0F0, 1'b0, 4'd1,  1'b1, 5'd15},
    '{32'h0000_F0F0, 1'b1, 4'd2,  1'b1, 5'd4},
    '{32'h0000_F0F0, 1'b0, 4'd3,  1'b1, 5'd15},
    '{32'h0000_F0F0, 1'b1, 4'd4,  1'b1, 5'd4}
  };

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic f, input logic [4:0] i, input logic [3:0] t);
    exp_t e;
    e.found = f;
    e.idx   = i;
    e.tag   = t;
    e.oh    = f ? (32'h1 << i) : 32'h0;
    return e;
  endfunction

  // Bit-by-bit reference: the last set bit met in scan order wins.
  function automatic exp_t model(input logic [31:0] d, input logic l, input logic [3:0] t);
    logic [4:0] i;
    i = '0;
    if (l) begin
      for (int b = 31; b >= 0; b--) if (d[b]) i = 5'(b);
    end else begin
      for (int b = 0; b < 32; b++) if (d[b]) i = 5'(b);
    end
    return mk(|d, i, t);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (lat_wait && out_valid) begin
      chk_eq("latency", 64'(cyc - t_in), 64'd2);
      lat_wait = 0;
    end
    if (lat_arm && in_valid && in_ready) begin
      t_in = cyc;
      lat_arm = 0;
      lat_wait = 1;
    end
    if (hold_pend && out_valid)
      chk_eq("stable_out", {out_found, out_index, out_tag}, held);
    if (out_valid && out_ready) begin
      rx_cnt++;
      if (sb.size() == 0) begin
        chk_eq("unexpected_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk_eq("out_found", out_found, e.found);
        chk_eq("out_index", out_index, e.idx);
        chk_eq("out_tag", out_tag, e.tag);
`ifdef HBS_ONEHOT_EN
        chk_eq("out_onehot", out_onehot, e.oh);
`endif
      end
    end
    hold_pend = out_valid && !out_ready;
    held = {out_found, out_index, out_tag};
  end

  // Called at posedge+1; returns at posedge+1 just after the word is taken.
  task automatic send(input logic [31:0] d, input logic l, input logic [3:0] t, input exp_t e);
    int n;
    bit done;
    n = 0;
    done = 0;
    input_data = d;
    in_lsb = l;
    in_tag = t;
    in_valid = 1'b1;
    while (!done && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk_eq("send_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk_eq({name, "_drain"}, 64'(sb.size()), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    logic [31:0] d;
    logic l;
    logic [3:0] t;

    rst = 1'b1; in_valid = 1'b0; input_data = '0; in_lsb = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_in_ready", in_ready, 0);
    chk_eq("rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_in_ready", in_ready, 1);
    chk_eq("post_rst_out_valid", out_valid, 0);
    chk_eq("post_rst_found", out_found, 0);
    chk_eq("post_rst_index", out_index, 0);
    chk_eq("post_rst_tag", out_tag, 0);
`ifdef HBS_ONEHOT_EN
    chk_eq("post_rst_onehot", out_onehot, 0);
`endif
    @(posedge clk);
    #1;

    // Byte stream, MSB then LSB, back to back.
    base = rx_cnt;
    lat_arm = 1;
    for (int i = 0; i < 10; i++) send({24'h0, stream_b[i]}, 1'b0, 4'(i), mk(1'b1, 5'd7, 4'(i)));
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_eq("msb_stream_rx", 64'(rx_cnt - base), 10);
    @(posedge clk);
    #1;
    base = rx_cnt;
    for (int i = 0; i < 10; i++) send({24'h0, stream_b[i]}, 1'b1, 4'(i), mk(1'b1, 5'(lsb_exp[i]), 4'(i)));
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_eq("lsb_stream_rx", 64'(rx_cnt - base), 10);
    @(posedge clk);
    #1;

    foreach (vecs[i]) send(vecs[i].d, vecs[i].lsb, vecs[i].tag, mk(vecs[i].f, vecs[i].idx, vecs[i].tag));
    drain("directed");

    // Fill the pipe, hold the output for 5 cycles with a third word waiting.
    out_ready = 1'b0;
    send(32'h0000_1000, 1'b0, 4'd6, mk(1'b1, 5'd12, 4'd6));
    send(32'h0000_0300, 1'b1, 4'd7, mk(1'b1, 5'd8, 4'd7));
    input_data = 32'h0400_0000; in_lsb = 1'b0; in_tag = 4'd8; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_eq("stall_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'h0400_0000, 1'b0, 4'd8, mk(1'b1, 5'd26, 4'd8));
    drain("stall");

    // Reset with two words in flight: neither may come out.
    out_ready = 1'b0;
    send(32'h0000_0010, 1'b0, 4'd9, mk(1'b1, 5'd4, 4'd9));
    send(32'h0000_0020, 1'b0, 4'd10, mk(1'b1, 5'd5, 4'd10));
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk_eq("midrst_in_ready", in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_found", out_found, 0);
    chk_eq("midrst_index", out_index, 0);
    chk_eq("midrst_tag", out_tag, 0);
    base = rx_cnt;
    repeat (4) @(negedge clk);
    #1 chk_eq("midrst_no_output", 64'(rx_cnt - base), 0);
    @(posedge clk);
    #1;

    // Random words against the reference model with random backpressure.
    base = rx_cnt;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          case ($urandom_range(0, 3))
            0: d = $urandom();
            1: d = 32'h1 << $urandom_range(0, 31);
            2: d = $urandom() & $urandom() & $urandom();
            default: d = ($urandom_range(0, 1) != 0) ? 32'h0 : 32'hFFFF_FFFF;
          endcase
          l = 1'($urandom_range(0, 1));
          t = 4'($urandom_range(0, 15));
          send(d, l, t, model(d, l, t));
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain("random");
    chk_eq("random_rx", 64'(rx_cnt - base), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
